// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state type for the multiport register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 1;
    localparam int DEF_ZERO_REG = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address mux, optional write bypass, zero masking, output flop.
// Bypass forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        regs [2**ADDR_W],
    input  logic                     clearing,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] rd_value;

    // NOTE: rd_value gets a default before any conditional update so no latch is inferred.
    always_comb begin
        rd_value = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan: the highest-indexed matching write port lands last and wins.
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                rd_value = wr_data[j*DATA_W +: DATA_W];
            end
        end
`endif
        if (clearing || ((ZERO_REG != 0) && (rd_addr == '0))) begin
            rd_value = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_value;
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with sequential clear FSM and registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [NUM_WR-1:0] wr_en_eff;

    // External writes only land while idle and not colliding with a clear request.
    assign wr_en_eff = ((state == IDLE) && !clr_req) ? wr_en : '0;
    assign clr_busy  = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        unique case (state)
            IDLE: begin
                clr_cnt_next = '0;
                if (clr_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    // NOTE: the storage array is reset explicitly because an async clear of every register is required.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else begin
            // Later ports overwrite earlier ones to the same address within this edge.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_eff[j] &&
                    !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                    regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_en[i]),
            .rd_addr (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .clearing(clr_busy),
            .wr_en   (wr_en_eff),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Randomized and directed bench for multiport_regfile against an array-based reference model.
// Expected bypass behaviour follows REGFILE_BYPASS_EN as seen by the bench build.
module tb_multiport_regfile;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             clr_req;
    logic             clr_busy;

    always #5 clk = ~clk;

    multiport_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    // Reference model: register contents, expected read outputs, remaining clear cycles.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_rd [NR];
    int            busy_left;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic drive_idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; clr_req = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < NR; i++) exp_rd[i] = '0;
        busy_left = 0;
    endtask

    // Apply the current inputs to the model, then advance the DUT one edge.
    task automatic tick();
        logic [DW-1:0] nxt [NR];
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) nxt[i] = exp_rd[i];
        if (busy_left > 0) begin
            for (int i = 0; i < NR; i++) if (rd_en[i]) nxt[i] = '0;
            busy_left--;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (rd_en[i]) begin
                    a = rd_addr[i*AW +: AW];
                    if (a == 0) begin
                        nxt[i] = '0;
                    end else begin
                        nxt[i] = model[a];
                        if (BYPASS && !clr_req)
                            for (int j = 0; j < NW; j++)
                                if (wr_en[j] && wr_addr[j*AW +: AW] == a) nxt[i] = wr_data[j*DW +: DW];
                    end
                end
            end
            if (clr_req) begin
                for (int k = 0; k < DEPTH; k++) model[k] = '0;
                busy_left = DEPTH;
            end else begin
                for (int j = 0; j < NW; j++)
                    if (wr_en[j] && wr_addr[j*AW +: AW] != 0) model[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) exp_rd[i] = nxt[i];
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_idle();
            set_wr(0, AW'(a), 32'h1000_0001 + a * 32'h0101_0101);
            set_wr(1, AW'(a + 1), 32'h2000_0003 + a * 32'h0003_0007);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (clr_busy !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: clr_busy=%b rd_data=%h expected 0", clr_busy, rd_data);
        end
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_idle();
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 1));
            tick();
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL reset_regs r%0d/r%0d: got %h expected 0", a, a + 1, rd_data);
            end
        end
    endtask

    task automatic test_basic_rw();
        drive_idle(); set_wr(0, 5'd5, 32'hDEADBEEF); tick();
        drive_idle(); set_rd(0, 5'd5); tick();
        n_checks++;
        if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rw: rd_data[0]=%h expected deadbeef", rd_data[0 +: DW]);
        end
    endtask

    task automatic test_zero_reg();
        drive_idle(); set_wr(0, 5'd0, 32'h12345678); set_rd(1, 5'd0); tick();
        drive_idle(); set_rd(0, 5'd0); tick();
        n_checks++;
        if (rd_data[0 +: DW] !== 32'h0 || rd_data[DW +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg: rd_data=%h expected 0", rd_data);
        end
    endtask

    task automatic test_write_priority();
        drive_idle(); set_wr(0, 5'd7, 32'hAAAA); set_wr(1, 5'd7, 32'h5555); tick();
        drive_idle(); set_rd(1, 5'd7); tick();
        n_checks++;
        if (rd_data[DW +: DW] !== 32'h5555) begin
            n_fail++;
            $display("FAIL write_priority: rd_data[1]=%h expected 5555", rd_data[DW +: DW]);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        drive_idle(); set_wr(0, 5'd3, 32'h1); tick();
        drive_idle(); set_rd(0, 5'd3); set_wr(1, 5'd3, 32'h2); tick();
        want = BYPASS ? 32'h2 : 32'h1;
        n_checks++;
        if (rd_data[0 +: DW] !== want) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rd_data[0]=%h expected %h", rd_data[0 +: DW], want);
        end
        drive_idle(); set_rd(0, 5'd3); tick();
        n_checks++;
        if (rd_data[0 +: DW] !== 32'h2) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: rd_data[0]=%h expected 2", rd_data[0 +: DW]);
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] held;
        held = rd_data[0 +: DW];
        drive_idle(); set_wr(0, 5'd3, 32'hFEED_F00D); tick();
        drive_idle(); tick();
        n_checks++;
        if (rd_data[0 +: DW] !== held || rd_data[0 +: DW] !== exp_rd[0]) begin
            n_fail++;
            $display("FAIL read_hold: rd_data[0]=%h expected %h", rd_data[0 +: DW], held);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive_idle();
            for (int p = 0; p < NW; p++)
                if ($urandom_range(1, 0) == 1)
                    set_wr(p, AW'($urandom_range(9, 0) == 0 ? $urandom_range(31, 0) : $urandom_range(7, 0)), $urandom);
            for (int p = 0; p < NR; p++)
                if ($urandom_range(2, 0) != 0)
                    set_rd(p, AW'($urandom_range(9, 0) == 0 ? $urandom_range(31, 0) : $urandom_range(7, 0)));
            tick();
            for (int p = 0; p < NR; p++) begin
                n_checks++;
                if (rd_data[p*DW +: DW] !== exp_rd[p]) begin
                    n_fail++;
                    $display("FAIL random_read cycle %0d port %0d: got %h expected %h", c, p, rd_data[p*DW +: DW], exp_rd[p]);
                end
            end
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        fill_all();
        // Clear request collides with a write to r2 (must be dropped) and a normal read of r5.
        drive_idle(); clr_req = 1'b1; set_wr(0, 5'd2, 32'h0BAD); set_rd(0, 5'd5); tick();
        n_checks++;
        if (rd_data[0 +: DW] !== exp_rd[0]) begin
            n_fail++;
            $display("FAIL clear_start_read: rd_data[0]=%h expected %h", rd_data[0 +: DW], exp_rd[0]);
        end
        busy_cnt = 0;
        while (clr_busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            drive_idle();
            set_rd(0, AW'($urandom_range(31, 1)));
            set_rd(1, AW'($urandom_range(31, 1)));
            if (busy_cnt == 5) begin
                clr_req = 1'b1;
                set_wr(1, 5'd9, 32'h7777);
            end
            tick();
            n_checks++;
            if (rd_data[0 +: DW] !== exp_rd[0] || rd_data[DW +: DW] !== exp_rd[1]) begin
                n_fail++;
                $display("FAIL clear_read_zero step %0d: got %h expected 0", busy_cnt, rd_data);
            end
        end
        n_checks++;
        if (busy_cnt != DEPTH) begin
            n_fail++;
            $display("FAIL clear_busy_len: busy for %0d cycles expected %0d", busy_cnt, DEPTH);
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_idle(); set_rd(0, AW'(a)); set_rd(1, AW'(a + 1)); tick();
            n_checks++;
            if (rd_data !== '0 || clr_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_result r%0d/r%0d: got %h busy=%b expected 0", a, a + 1, rd_data, clr_busy);
            end
        end
    endtask

    task automatic test_clear_abort();
        fill_all();
        drive_idle(); set_rd(0, 5'd4); tick();
        drive_idle(); clr_req = 1'b1; tick();
        drive_idle();
        repeat (9) tick();
        rst = 1'b1;
        #2;
        n_checks++;
        if (clr_busy !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL abort_in_reset: clr_busy=%b rd_data=%h expected 0", clr_busy, rd_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_idle(); set_rd(0, AW'(a)); set_rd(1, AW'(a + 1)); tick();
            n_checks++;
            if (rd_data !== '0 || clr_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_regs r%0d/r%0d: got %h busy=%b expected 0", a, a + 1, rd_data, clr_busy);
            end
        end
        drive_idle(); set_wr(0, 5'd1, 32'h99); tick();
        drive_idle(); set_rd(1, 5'd1); tick();
        n_checks++;
        if (rd_data[DW +: DW] !== 32'h99) begin
            n_fail++;
            $display("FAIL abort_write_after: rd_data[1]=%h expected 99", rd_data[DW +: DW]);
        end
    endtask

    task automatic test_back_to_back();
        // Write and read on every edge; each read sees the previous edge's write.
        for (int c = 1; c < 12; c++) begin
            drive_idle();
            set_wr(0, AW'(c + 10), 32'hB000_0000 + c);
            if (c > 1) set_rd(0, AW'(c + 9));
            tick();
            if (c > 1) begin
                n_checks++;
                if (rd_data[0 +: DW] !== 32'hB000_0000 + c - 1) begin
                    n_fail++;
                    $display("FAIL back_to_back r%0d: got %h expected %h", c + 9, rd_data[0 +: DW], 32'hB000_0000 + c - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_write_priority();
        test_bypass();
        test_hold();
        test_back_to_back();
        test_random();
        test_clear();
        test_clear_abort();
        drive_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
